padd_result_buffer: RTL

//  Downstream companion of the fully pipelined ripple adder. The adder has no valid, stall or reset.

---
 rtl/padd_pkg.sv | 39 +++
 rtl/padd_sync_fifo.sv | 93 +++++++++
 rtl/padd_result_buffer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/padd_pkg.sv
// ---------------------------------------------------------------------------
// padd_pkg
// Shared definitions for the pipelined-adder result buffer.
//   - clog2()                : ceiling log2, usable in constant expressions
//   - PADD_WIDTH/PADD_DEPTH  : default adder width and result FIFO depth
//   - CR_W / PTR_W           : credit-counter and FIFO-pointer widths for the
//                              default geometry
//   - REC_W, REC_SUM_LSB,
//     REC_CARRY_BIT          : result record {carry, sum} layout
// Optional feature (see padd_result_buffer): PADD_OVF_COUNT_EN
// ---------------------------------------------------------------------------
package padd_pkg;

    localparam int PADD_WIDTH = 4;
    localparam int PADD_DEPTH = 8;

    // Smallest r with 2**r >= value (clog2(1) == 0).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Credit counter spans 0..DEPTH inclusive, hence DEPTH+1 states.
    localparam int CR_W  = clog2(PADD_DEPTH + 1);
    localparam int PTR_W = clog2(PADD_DEPTH);

    // Result record: sum in the low bits, carry directly above it.
    localparam int REC_W         = PADD_WIDTH + 1;
    localparam int REC_SUM_LSB   = 0;
    localparam int REC_CARRY_BIT = PADD_WIDTH;

endpackage

// File: rtl/padd_sync_fifo.sv
// ---------------------------------------------------------------------------
// padd_sync_fifo
// Single-clock FIFO holding adder results. The head entry is presented
// combinationally on dout (no extra register after pop), so a newly pushed
// entry becomes visible the cycle after its push edge.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (pointers/count only)
//   push, din  : write din at the tail on a rising edge when push=1
//   pop        : retire the head on a rising edge when pop=1
//   dout       : current head entry (meaningful only while empty=0)
//   empty,full : occupancy flags
// Push while full and pop while empty are ignored, so the count can never
// leave 0..DEPTH even if a caller misbehaves.
// ---------------------------------------------------------------------------
module padd_sync_fifo
    import padd_pkg::*;
#(
    parameter int WIDTH = REC_W,
    parameter int DEPTH = PADD_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    // Package widths describe the default geometry; other depths derive their own.
    localparam int PTR_BITS = (DEPTH == PADD_DEPTH) ? PTR_W : ((clog2(DEPTH) < 1) ? 1 : clog2(DEPTH));
    localparam int CNT_BITS = (DEPTH == PADD_DEPTH) ? CR_W  : clog2(DEPTH + 1);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                push_ok;
    logic                pop_ok;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        if (p == PTR_BITS'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_BITS'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/padd_result_buffer.sv
// ---------------------------------------------------------------------------
// padd_result_buffer
// Companion of a fully pipelined WIDTH-bit ripple adder that has no valid,
// stall or reset. A valid token travels alongside each issued operand; when
// it reaches the end of the delay line the adder outputs are captured into
// a result FIFO. Operand issue is gated by a credit count so every result
// emerging from the adder finds a free FIFO slot.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand issue handshake (issue = in_valid & in_ready)
//   add_s, add_c         : adder sum / carry outputs
//   out_valid/out_ready  : result handshake; out_sum/out_carry hold the head
//   ovf_count            : number of popped results with carry=1
// Optional feature: define PADD_OVF_COUNT_EN to build the saturating
// ovf_count counter; otherwise ovf_count is tied to zero.
// ---------------------------------------------------------------------------
module padd_result_buffer
    import padd_pkg::*;
#(
    parameter int WIDTH = PADD_WIDTH,
    parameter int DEPTH = PADD_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [15:0]      ovf_count
);

    localparam int CNT_BITS  = (DEPTH == PADD_DEPTH) ? CR_W : clog2(DEPTH + 1);
    localparam int REC_BITS  = (WIDTH == PADD_WIDTH) ? REC_W : WIDTH + 1;
    localparam int CARRY_POS = (WIDTH == PADD_WIDTH) ? REC_CARRY_BIT : WIDTH;

    logic                issue;
    logic                push;
    logic                pop;
    logic [WIDTH-1:0]    vld_q, vld_d;
    logic [CNT_BITS-1:0] cr_q, cr_d;
    logic [REC_BITS-1:0] rec_in;
    logic [REC_BITS-1:0] rec_head;
    logic                fifo_empty;
    // The credit scheme guarantees no push ever meets a full FIFO, so the
    // flag has no consumer here.
    logic                fifo_full_unused;

    assign in_ready = (cr_q != '0);
    assign issue    = in_valid & in_ready;
    assign push     = vld_q[WIDTH-1];
    assign pop      = out_valid & out_ready;

    // Token delay line matched to the adder latency: vld_q[WIDTH-1] is high
    // exactly while add_s/add_c belong to an issued operand.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue;
        for (int k = 1; k < WIDTH; k++) begin
            vld_d[k] = vld_q[k-1];
        end
    end

    // A credit leaves on issue and returns on pop, so
    // credits + in-flight tokens + FIFO occupancy is always DEPTH.
    always_comb begin
        case ({issue, pop})
            2'b10:   cr_d = cr_q - 1'b1;
            2'b01:   cr_d = cr_q + 1'b1;
            default: cr_d = cr_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cr_q  <= CNT_BITS'(DEPTH);
        end else begin
            vld_q <= vld_d;
            cr_q  <= cr_d;
        end
    end

    always_comb begin
        rec_in                         = '0;
        rec_in[REC_SUM_LSB +: WIDTH]   = add_s;
        rec_in[CARRY_POS]              = add_c;
    end

    padd_sync_fifo #(
        .WIDTH (REC_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (rec_in),
        .pop   (pop),
        .dout  (rec_head),
        .empty (fifo_empty),
        .full  (fifo_full_unused)
    );

    assign out_valid = ~fifo_empty;
    // Mask the head while empty so the outputs read zero after reset rather
    // than whatever the unreset storage holds.
    assign out_sum   = out_valid ? rec_head[REC_SUM_LSB +: WIDTH] : '0;
    assign out_carry = out_valid & rec_head[CARRY_POS];

`ifdef PADD_OVF_COUNT_EN
    logic [15:0] ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (pop && out_carry && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_count = ovf_q;
`else
    assign ovf_count = 16'h0000;
`endif

endmodule
